countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable down-counter / interval timer, the decrementing counterpart of the team's generic up-counter. It accepts a period over a valid/ready load handshake, counts down one step per enabled tick once started, and emits a one-cycle terminal-count pulse. It runs either as a one-shot or with automatic reload, and is used for timeouts, periodic strobes and pulse-width generation.

## Interface
- `N_BITS`, default 16: width of the counter and load value.
- `clk`  in  1  main FPGA clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous reset, active low.
- `load_valid`  in  1  load request; `load_value` is valid while high.
- `load_value`  in  N_BITS  period to load.
- `load_ready`  out  1  load accepted on any cycle where `load_valid && load_ready`.
- `mode`  in  1  0 = one-shot, 1 = auto-reload; sampled only when a start is accepted.
- `start`  in  1  start or resume counting.
- `stop`  in  1  freeze counting.
- `en`  in  1  count tick; one decrement per high cycle while running.
- `count`  out  N_BITS  current counter value.
- `busy`  out  1  high while in RUN.
- `tc`  out  1  terminal-count pulse, one clock wide.

## Operation
- States: IDLE, LOADED, RUN, HOLD. Internal registers: `reload` (N_BITS) and latched mode `mode_q`.
- `load_ready` = state is IDLE, LOADED or HOLD. It is combinational from the state register and is 0 in RUN.
- Accepted load: `count <= load_value`, `reload <= load_value`, next state LOADED. This applies from HOLD as well and abandons the held run.
- LOADED or HOLD, `start=1`, `stop=0`, `count!=0` → RUN, with `mode_q <= mode`.
- If `count==0`, start is ignored and the state is unchanged.
- If a load and a start arrive in the same cycle, the load wins and the state becomes LOADED.
- IDLE: start is ignored, because IDLE always holds either `count==0` or the reset state.
- RUN, `stop=1` → HOLD, with `count` frozen. Stop has priority over `en` in that cycle, so there is no decrement.
- `stop` in IDLE, LOADED or HOLD is ignored.
- RUN, `stop=0`, `en=1`:
  - `count>1`: `count <= count-1`.
  - `count==1`: `tc <= 1`.
    - `mode_q=1`: `count <= reload` and the block stays in RUN.
    - `mode_q=0`: `count <= 0` and the state becomes IDLE.
- RUN, `en=0`: `count` holds.
- `start` while in RUN is ignored.
- Arithmetic is unsigned. Count never wraps below 0. The maximum period is 2^N_BITS − 1 ticks.
- Period: in auto-reload with `reload=R`, `tc` fires exactly every R enabled ticks.
- `busy` = state is RUN.

## Timing
- Reset (`rst_n=0`, asynchronous assert, synchronous release to the next edge):
  - `count=0`, state IDLE, `reload=0`, `mode_q=0`.
  - `tc=0`, `busy=0`, `load_ready=1`.
- Reset mid-run aborts immediately. No `tc` is produced.
- Load latency: the value appears on `count` at the accepting edge. The state is LOADED from the next cycle.
- Start latency: `busy` rises at the edge after `start`. The `en` in the start cycle itself is not counted; the first decrement is the first `en` cycle with `busy=1`.
- `tc` is registered and rises at the same edge at which `count` becomes 0 or is reloaded. It is high for exactly one cycle.
- One-shot: `busy` falls at the same edge `tc` rises.
- Back-to-back `en` in auto-reload with R=1: `tc` is high every `en` cycle and `count` stays at 1.

## Test plan
- Reset, load 5, start with mode=0, `en` held high:
  - `busy` rises 1 cycle after start.
  - `count` goes 4,3,2,1,0.
  - `tc` pulses once, in the cycle `count` reaches 0.
  - `busy=0`, state IDLE.
- Load 3, mode=1, `en` high for 10 cycles:
  - `tc` pulses after ticks 3, 6, 9.
  - `count` sequence is 2,1,3,2,1,3,… and `busy` stays 1.
- Load 4, start, 2 ticks to reach `count=2`, then `stop` together with `en`:
  - `count` stays 2 and state is HOLD.
  - Restart: 2 more ticks → `tc`.
  - Loading 7 while in HOLD sets `count=7`.
- Handshake and edge cases:
  - `load_valid` during RUN is not accepted (`load_ready=0`) and `count` is unaffected.
  - Load 0 then start: start is ignored, state stays LOADED, no `tc`.
- Simultaneous load and start in LOADED: the load wins, so `count` = new value and `busy` stays 0.
- Assert `rst_n=0` mid-count in auto-reload: all outputs go to reset values immediately, with no `tc`.
- `en` toggling 1/0 in one-shot with load 3: decrements only on `en` cycles, and `tc` comes after the 3rd enabled tick.

Source files
------------

// File: rtl/countdown_timer.sv
// Loadable down-counter / interval timer with a valid/ready load port,
// one-shot or auto-reload operation and a registered one-cycle terminal-count pulse.
module countdown_timer #(
  parameter int N_BITS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [N_BITS-1:0] load_value,
  output logic              load_ready,
  input  logic              mode,
  input  logic              start,
  input  logic              stop,
  input  logic              en,
  output logic [N_BITS-1:0] count,
  output logic              busy,
  output logic              tc
);

  typedef enum logic [1:0] {IDLE, LOADED, RUN, HOLD} state_t;

  state_t            state, state_nxt;
  logic [N_BITS-1:0] count_nxt;
  logic [N_BITS-1:0] reload, reload_nxt;
  logic              mode_q, mode_nxt;
  logic              tc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      mode_q <= 1'b0;
      tc     <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      reload <= reload_nxt;
      mode_q <= mode_nxt;
      tc     <= tc_nxt;
    end
  end

  assign load_ready = (state != RUN);
  assign busy       = (state == RUN);

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload;
    mode_nxt   = mode_q;
    tc_nxt     = 1'b0;
    case (state)
      IDLE, LOADED, HOLD: begin
        // A load beats a simultaneous start; IDLE never has a startable count.
        if (load_valid) begin
          count_nxt  = load_value;
          reload_nxt = load_value;
          state_nxt  = LOADED;
        end else if (state != IDLE && start && !stop && count != '0) begin
          state_nxt = RUN;
          mode_nxt  = mode;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = HOLD;
        end else if (en) begin
          if (count > N_BITS'(1)) begin
            count_nxt = count - N_BITS'(1);
          end else begin
            // Terminal tick: a count of 1 (0 is unreachable while running).
            tc_nxt = 1'b1;
            if (mode_q) begin
              count_nxt = reload;
            end else begin
              count_nxt = '0;
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboarded bench for countdown_timer: each driven cycle queues the expected
// count/tc/busy, which a negedge monitor compares one cycle later.
module tb_countdown_timer;

  localparam int N_BITS = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_valid;
  logic [N_BITS-1:0] load_value;
  logic              load_ready;
  logic              mode, start, stop, en;
  logic [N_BITS-1:0] count;
  logic              busy, tc;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    string             tag;
    int                due;
    logic [N_BITS-1:0] cnt;
    logic              tc;
    logic              busy;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;

  countdown_timer #(.N_BITS(N_BITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .mode       (mode),
    .start      (start),
    .stop       (stop),
    .en         (en),
    .count      (count),
    .busy       (busy),
    .tc         (tc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (count !== mon_e.cnt || tc !== mon_e.tc || busy !== mon_e.busy) begin
        errors++;
        $display("FAIL %s: got count=%0d tc=%b busy=%b, want count=%0d tc=%b busy=%b",
                 mon_e.tag, count, tc, busy, mon_e.cnt, mon_e.tc, mon_e.busy);
      end
    end
  end

  // Drive one cycle of stimulus (called at a negedge) and queue the post-edge outputs.
  task automatic step(input string tag, input logic lv, input logic [N_BITS-1:0] lval,
                      input logic md, input logic st, input logic sp, input logic e,
                      input logic [N_BITS-1:0] ecnt, input logic etc, input logic ebusy);
    sb_t x;
    load_valid = lv; load_value = lval; mode = md; start = st; stop = sp; en = e;
    x.tag = tag; x.due = cyc + 1; x.cnt = ecnt; x.tc = etc; x.busy = ebusy;
    sb.push_back(x);
    @(negedge clk);
    load_valid = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_valid = 0; load_value = '0; mode = 0; start = 0; stop = 0; en = 0;
    #12;
    checks++;
    if (count !== '0 || tc !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: got count=%0d tc=%b busy=%b ready=%b, want 0 0 0 1",
               count, tc, busy, load_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_oneshot();
    step("os_load5", 1, 5, 0, 0, 0, 0, 5, 0, 0);
    step("os_start", 0, 0, 0, 1, 0, 1, 5, 0, 1);
    step("os_t1",    0, 0, 0, 0, 0, 1, 4, 0, 1);
    step("os_t2",    0, 0, 0, 0, 0, 1, 3, 0, 1);
    step("os_t3",    0, 0, 0, 0, 0, 1, 2, 0, 1);
    step("os_t4",    0, 0, 0, 0, 0, 1, 1, 0, 1);
    step("os_t5",    0, 0, 0, 0, 0, 1, 0, 1, 0);
    step("os_after", 0, 0, 0, 1, 0, 1, 0, 0, 0);
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL os_ready_idle: got %b want 1", load_ready);
    end
  endtask

  task automatic test_autoreload();
    logic [N_BITS-1:0] exp_cnt[10] = '{2, 1, 3, 2, 1, 3, 2, 1, 3, 2};
    logic              exp_tc [10] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    step("ar_load3", 1, 3, 0, 0, 0, 0, 3, 0, 0);
    step("ar_start", 0, 0, 1, 1, 0, 1, 3, 0, 1);
    for (int i = 0; i < 10; i++)
      step($sformatf("ar_tick%0d", i + 1), 0, 0, 0, 0, 0, 1, exp_cnt[i], exp_tc[i], 1);
    step("ar_stop",  0, 0, 0, 0, 1, 1, 2, 0, 0);
  endtask

  task automatic test_stop_hold();
    step("sh_load4",   1, 4, 0, 0, 0, 0, 4, 0, 0);
    step("sh_start",   0, 0, 0, 1, 0, 0, 4, 0, 1);
    step("sh_t1",      0, 0, 0, 0, 0, 1, 3, 0, 1);
    step("sh_t2",      0, 0, 0, 0, 0, 1, 2, 0, 1);
    step("sh_stop_en", 0, 0, 0, 0, 1, 1, 2, 0, 0);
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL sh_ready_hold: got %b want 1", load_ready);
    end
    step("sh_stop_ign", 0, 0, 0, 0, 1, 1, 2, 0, 0);
    step("sh_restart",  0, 0, 0, 1, 0, 1, 2, 0, 1);
    step("sh_t3",       0, 0, 0, 0, 0, 1, 1, 0, 1);
    step("sh_t4",       0, 0, 0, 0, 0, 1, 0, 1, 0);
    step("sh_load4b",   1, 4, 0, 0, 0, 0, 4, 0, 0);
    step("sh_start2",   0, 0, 0, 1, 0, 1, 4, 0, 1);
    step("sh_t5",       0, 0, 0, 0, 0, 1, 3, 0, 1);
    step("sh_stop2",    0, 0, 0, 0, 1, 0, 3, 0, 0);
    step("sh_load7",    1, 7, 0, 0, 0, 0, 7, 0, 0);
  endtask

  task automatic test_handshake();
    step("hs_load6", 1, 6, 0, 0, 0, 0, 6, 0, 0);
    step("hs_start", 0, 0, 0, 1, 0, 0, 6, 0, 1);
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL hs_ready_run: got %b want 0", load_ready);
    end
    step("hs_load_run",    1, 9, 0, 0, 0, 0, 6, 0, 1);
    step("hs_load_run_en", 1, 9, 0, 0, 0, 1, 5, 0, 1);
    step("hs_stop",        0, 0, 0, 0, 1, 0, 5, 0, 0);
    step("hs_load0",       1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("hs_start0",      0, 0, 0, 1, 0, 1, 0, 0, 0);
    step("hs_start0b",     0, 0, 1, 1, 0, 1, 0, 0, 0);
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL hs_ready_loaded0: got %b want 1", load_ready);
    end
  endtask

  task automatic test_load_start_same();
    step("ls_load2",  1, 2, 0, 0, 0, 0, 2, 0, 0);
    step("ls_both",   1, 8, 0, 1, 0, 1, 8, 0, 0);
    step("ls_start",  0, 0, 0, 1, 0, 0, 8, 0, 1);
    step("ls_stop",   0, 0, 0, 0, 1, 0, 8, 0, 0);
  endtask

  task automatic test_reset_midrun();
    step("rm_load3", 1, 3, 0, 0, 0, 0, 3, 0, 0);
    step("rm_start", 0, 0, 1, 1, 0, 0, 3, 0, 1);
    step("rm_t1",    0, 0, 0, 0, 0, 1, 2, 0, 1);
    step("rm_t2",    0, 0, 0, 0, 0, 1, 1, 0, 1);
    step("rm_t3",    0, 0, 0, 0, 0, 1, 3, 1, 1);
    step("rm_t4",    0, 0, 0, 0, 0, 1, 2, 0, 1);
    #1;
    en = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== '0 || tc !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_async: got count=%0d tc=%b busy=%b ready=%b, want 0 0 0 1",
               count, tc, busy, load_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (count !== '0 || tc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rm_held: got count=%0d tc=%b busy=%b, want 0 0 0", count, tc, busy);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("rm_idle_start", 0, 0, 0, 1, 0, 1, 0, 0, 0);
  endtask

  task automatic test_en_toggle();
    step("et_load3", 1, 3, 0, 0, 0, 0, 3, 0, 0);
    step("et_start", 0, 0, 0, 1, 0, 0, 3, 0, 1);
    step("et_e1",    0, 0, 0, 0, 0, 1, 2, 0, 1);
    step("et_e0a",   0, 0, 0, 0, 0, 0, 2, 0, 1);
    step("et_e2",    0, 0, 0, 0, 0, 1, 1, 0, 1);
    step("et_e0b",   0, 0, 0, 0, 0, 0, 1, 0, 1);
    step("et_e3",    0, 0, 0, 0, 0, 1, 0, 1, 0);
    step("et_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    step("bb_load1", 1, 1, 0, 0, 0, 0, 1, 0, 0);
    step("bb_start", 0, 0, 1, 1, 0, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++)
      step($sformatf("bb_tick%0d", i + 1), 0, 0, 0, 0, 0, 1, 1, 1, 1);
    step("bb_stop",  0, 0, 0, 0, 1, 1, 1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_stop_hold();
    test_handshake();
    test_load_start_same();
    test_reset_midrun();
    test_en_toggle();
    test_back_to_back();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending entries want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
